bcd_counter_seq: RTL and testbench

//  Parametrised up/down counter with preload and an on-chip sequential binary-to-BCD converter.

---
 rtl/bcd_counter_seq.sv | 164 ++++++++++++++++
 tb/tb_bcd_counter_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_seq.sv
// bcd_counter_seq
//   Up/down counter with synchronous preload, followed by a sequential
//   shift-add-3 (double dabble) binary-to-BCD converter. The converter
//   handles one bit per clock, so the display path gets a registered BCD
//   value and a valid strobe without a wide combinational decoder.
//
// Ports
//   clk        in   1           clock, all state on rising edge
//   rst        in   1           asynchronous, active-high reset
//   en         in   1           count enable
//   up         in   1           1 = increment, 0 = decrement
//   ld         in   1           synchronous preload strobe (has priority over en)
//   v          in   WIDTH       preload value
//   count      out  WIDTH       registered binary count
//   bcd        out  4*DIGITS    last completed conversion, digit 0 = bcd[3:0]
//   bcd_valid  out  1           one-cycle pulse, bcd just updated
//   busy       out  1           conversion in progress
//
// Converter states
//   state | meaning
//   IDLE  | waiting for count to differ from the last converted value
//   SHIFT | running WIDTH adjust+shift steps on the captured snapshot

module bcd_counter_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      v,
    output logic [WIDTH-1:0]      count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

    // The digit count must be able to represent every counter value.
    function automatic bit digits_fit(input int w, input int d);
        longint unsigned cap;
        cap = 64'd1;
        for (int i = 0; i < d; i++) begin
            cap = cap * 64'd10;
        end
        return (cap >= (64'd1 << w));
    endfunction

    if (!digits_fit(WIDTH, DIGITS)) begin : g_digits_check
        $error("bcd_counter_seq: 10**DIGITS must be >= 2**WIDTH");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [WIDTH-1:0]  snap_q, snap_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              bcd_valid_q, bcd_valid_d;
    logic              busy_q, busy_d;

    logic [BW-1:0]     adjusted;
    logic [BW-1:0]     shifted;

    // Each nibble is corrected independently; a corrected nibble never
    // exceeds 4'hC, so no carry crosses into the next digit before the shift.
    always_comb begin
        adjusted = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[BW-2:0], snap_q[WIDTH-1]};
    end

    always_comb begin
        count_d     = count_q;
        state_d     = state_q;
        last_d      = last_q;
        snap_d      = snap_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        busy_d      = busy_q;

        if (ld) begin
            count_d = v;
        end else if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                // last_q remembers what was converted, so a settled count
                // that moved during a conversion is picked up here.
                if (count_q != last_q) begin
                    snap_d    = count_q;
                    last_d    = count_q;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                snap_d    = snap_q << 1;
                iter_d    = iter_q + 1'b1;
                if (iter_q == LAST_ITER) begin
                    bcd_d       = shifted;
                    bcd_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            last_q      <= '0;
            snap_q      <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_q      <= last_d;
            snap_q      <= snap_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign count     = count_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_counter_seq.sv
// tb_bcd_counter_seq
//   Two instances: the default 8-bit/3-digit counter and a 12-bit/4-digit
//   one. Expected BCD results are queued when the stimulus that causes them
//   is applied and popped by a negedge monitor on every bcd_valid pulse.

module tb_bcd_counter_seq;

    logic        clk;
    logic        rst;

    logic        en_a, up_a, ld_a;
    logic [7:0]  v_a;
    logic [7:0]  count_a;
    logic [11:0] bcd_a;
    logic        valid_a, busy_a;

    logic        en_b, up_b, ld_b;
    logic [11:0] v_b;
    logic [11:0] count_b;
    logic [15:0] bcd_b;
    logic        valid_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    bcd_counter_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en_a),
        .up        (up_a),
        .ld        (ld_a),
        .v         (v_a),
        .count     (count_a),
        .bcd       (bcd_a),
        .bcd_valid (valid_a),
        .busy      (busy_a)
    );

    bcd_counter_seq #(.WIDTH(12), .DIGITS(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en_b),
        .up        (up_b),
        .ld        (ld_b),
        .v         (v_b),
        .count     (count_b),
        .bcd       (bcd_b),
        .bcd_valid (valid_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the capture edge, then for busy to drop (bounded).
    task automatic settle(input bit sel_b);
        int k;
        step(2);
        k = 0;
        while ((sel_b ? busy_b : busy_a) && k < 200) begin
            step(1);
            k++;
        end
        check(sel_b ? "settle_timeout_b" : "settle_timeout_a",
              32'(sel_b ? busy_b : busy_a), 32'd0);
    endtask

    // Scoreboard: every bcd_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && valid_a) begin
            n_cmp++;
            assert (q_a.size() > 0) else begin
                n_err++;
                $error("FAIL sb_a_unexpected_valid: observed bcd %0h expected no pulse", bcd_a);
            end
            if (q_a.size() > 0) check("sb_a_bcd", 32'(bcd_a), 32'(q_a.pop_front()));
        end
        if (!rst && valid_b) begin
            n_cmp++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("FAIL sb_b_unexpected_valid: observed bcd %0h expected no pulse", bcd_b);
            end
            if (q_b.size() > 0) check("sb_b_bcd", 32'(bcd_b), 32'(q_b.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        en_a = 1'b0; up_a = 1'b0; ld_a = 1'b0; v_a = '0;
        en_b = 1'b0; up_b = 1'b0; ld_b = 1'b0; v_b = '0;
        step(3);
        rst = 1'b0;

        // 1: idle after reset, no conversion may follow
        step(20);
        check("t1_count", 32'(count_a), 32'd0);
        check("t1_bcd",   32'(bcd_a),   32'h000);
        check("t1_busy",  32'(busy_a),  32'd0);
        check("t1_valid", 32'(valid_a), 32'd0);

        // 2: preload 255, exact latency of the conversion
        ld_a = 1'b1; v_a = 8'd255;
        q_a.push_back(16'h255);
        step(1);
        ld_a = 1'b0;
        check("t2_count", 32'(count_a), 32'd255);
        check("t2_busy_pre", 32'(busy_a), 32'd0);
        step(1);
        check("t2_busy_capture", 32'(busy_a), 32'd1);
        step(7);
        check("t2_busy_last", 32'(busy_a), 32'd1);
        check("t2_no_partial", 32'(bcd_a), 32'h000);
        step(1);
        check("t2_busy_done", 32'(busy_a), 32'd0);
        check("t2_valid", 32'(valid_a), 32'd1);
        check("t2_bcd", 32'(bcd_a), 32'h255);
        step(1);
        check("t2_valid_single", 32'(valid_a), 32'd0);

        // 3: back to 0, then count up 10; value 1 is captured, 2..9 skipped, 10 settles
        ld_a = 1'b1; v_a = 8'd0;
        q_a.push_back(16'h000);
        step(1);
        ld_a = 1'b0;
        settle(1'b0);
        en_a = 1'b1; up_a = 1'b1;
        q_a.push_back(16'h001);
        q_a.push_back(16'h010);
        step(10);
        en_a = 1'b0;
        check("t3_count", 32'(count_a), 32'd10);
        settle(1'b0);
        check("t3_bcd", 32'(bcd_a), 32'h010);
        step(12);
        check("t3_idle", 32'(busy_a), 32'd0);

        // 4: wrap in both directions
        ld_a = 1'b1; v_a = 8'd255;
        q_a.push_back(16'h255);
        step(1);
        ld_a = 1'b0;
        settle(1'b0);
        en_a = 1'b1; up_a = 1'b1;
        q_a.push_back(16'h000);
        step(1);
        en_a = 1'b0;
        check("t4_wrap_up_count", 32'(count_a), 32'd0);
        settle(1'b0);
        check("t4_wrap_up_bcd", 32'(bcd_a), 32'h000);
        en_a = 1'b1; up_a = 1'b0;
        q_a.push_back(16'h255);
        step(1);
        en_a = 1'b0;
        check("t4_wrap_dn_count", 32'(count_a), 32'd255);
        settle(1'b0);
        check("t4_wrap_dn_bcd", 32'(bcd_a), 32'h255);

        // 5: reload while busy; snapshot converts first, then the new value
        ld_a = 1'b1; v_a = 8'd100;
        q_a.push_back(16'h100);
        step(2);
        ld_a = 1'b0;
        check("t5_busy", 32'(busy_a), 32'd1);
        ld_a = 1'b1; v_a = 8'd42;
        q_a.push_back(16'h042);
        step(1);
        ld_a = 1'b0;
        settle(1'b0);
        check("t5_first_bcd", 32'(bcd_a), 32'h100);
        settle(1'b0);
        check("t5_second_bcd", 32'(bcd_a), 32'h042);

        // 6: asynchronous reset in the middle of a conversion
        ld_a = 1'b1; v_a = 8'd200;
        step(1);
        ld_a = 1'b0;
        step(3);
        check("t6_busy_before", 32'(busy_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_busy",  32'(busy_a),  32'd0);
        check("t6_async_bcd",   32'(bcd_a),   32'h000);
        check("t6_async_count", 32'(count_a), 32'd0);
        check("t6_async_valid", 32'(valid_a), 32'd0);
        step(3);
        rst = 1'b0;
        step(12);
        check("t6_post_busy", 32'(busy_a), 32'd0);
        check("t6_post_bcd",  32'(bcd_a),  32'h000);

        // 12-bit / 4-digit instance
        ld_b = 1'b1; v_b = 12'd4095;
        q_b.push_back(16'h4095);
        step(1);
        ld_b = 1'b0;
        check("tb_count_4095", 32'(count_b), 32'd4095);
        settle(1'b1);
        check("tb_bcd_4095", 32'(bcd_b), 32'h4095);
        ld_b = 1'b1; v_b = 12'd1234;
        q_b.push_back(16'h1234);
        step(1);
        ld_b = 1'b0;
        settle(1'b1);
        check("tb_bcd_1234", 32'(bcd_b), 32'h1234);

        step(3);
        check("sb_a_drained", 32'(q_a.size()), 32'd0);
        check("sb_b_drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
